// File: rtl/alarm_output_driver_if.sv
// alarm_output_driver_if: alarm FSM level requests in, pad/relay drives out.
// master = car_alarm_fsm side, slave = output driver side.
interface alarm_output_driver_if;
  logic system_arm;
  logic siren;
  logic led;
  logic fuel_pump_power;
  logic led_out;
  logic siren_out;
  logic pump_relay;
  logic siren_timeout;

  modport master (
    output system_arm, siren, led, fuel_pump_power,
    input  led_out, siren_out, pump_relay, siren_timeout
  );

  modport slave (
    input  system_arm, siren, led, fuel_pump_power,
    output led_out, siren_out, pump_relay, siren_timeout
  );
endinterface

// File: rtl/alarm_output_driver.sv
// alarm_output_driver: LED blink, siren cadence/time-limit and
// fuel-pump enable delay between car_alarm_fsm and the output pads.
module alarm_output_driver #(
  parameter int TICK_DIV         = 4,
  parameter int LED_ON_TICKS     = 2,
  parameter int LED_OFF_TICKS    = 6,
  parameter int SIREN_ON_TICKS   = 3,
  parameter int SIREN_OFF_TICKS  = 2,
  parameter int SIREN_MAX_TICKS  = 30,
  parameter int PUMP_DELAY_TICKS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  alarm_output_driver_if.slave bus
);

  localparam int LED_MAX =
    (LED_ON_TICKS > LED_OFF_TICKS) ? LED_ON_TICKS : LED_OFF_TICKS;
  localparam int SPH_MAX =
    (SIREN_ON_TICKS > SIREN_OFF_TICKS) ? SIREN_ON_TICKS
                                       : SIREN_OFF_TICKS;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LW = (LED_MAX > 1) ? $clog2(LED_MAX) : 1;
  localparam int SW = (SPH_MAX > 1) ? $clog2(SPH_MAX) : 1;
  localparam int TW =
    (SIREN_MAX_TICKS > 1) ? $clog2(SIREN_MAX_TICKS) : 1;
  localparam int DW =
    (PUMP_DELAY_TICKS > 1) ? $clog2(PUMP_DELAY_TICKS) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [LW-1:0] LON_LAST = LW'(LED_ON_TICKS - 1);
  localparam logic [LW-1:0] LOFF_LAST = LW'(LED_OFF_TICKS - 1);
  localparam logic [SW-1:0] SON_LAST = SW'(SIREN_ON_TICKS - 1);
  localparam logic [SW-1:0] SOFF_LAST = SW'(SIREN_OFF_TICKS - 1);
  localparam logic [TW-1:0] TOT_LAST = TW'(SIREN_MAX_TICKS - 1);
  localparam logic [DW-1:0] DLY_LAST =
    DW'((PUMP_DELAY_TICKS > 0) ? PUMP_DELAY_TICKS - 1 : 0);

  typedef enum logic [1:0] {
    LED_OFF,
    LED_SLOW,
    LED_FAST
  } led_mode_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF,
    S_MUTED
  } siren_st_t;

  typedef enum logic [1:0] {
    P_OFF,
    P_WAIT,
    P_ON
  } pump_st_t;

  logic [PW-1:0] pre_cnt;
  logic          tick;

  led_mode_t     led_mode;
  led_mode_t     led_want;
  logic [LW-1:0] lcnt;
  logic          lvl;
  logic          led_q;

  siren_st_t     st;
  logic [SW-1:0] scnt;
  logic [TW-1:0] tcnt;
  logic          siren_q;
  logic          tmo_q;

  pump_st_t      pst;
  logic [DW-1:0] dcnt;
  logic          relay_q;

  assign tick = (pre_cnt == PRE_LAST);

  assign bus.led_out       = led_q;
  assign bus.siren_out     = siren_q;
  assign bus.pump_relay    = relay_q;
  assign bus.siren_timeout = tmo_q;

  // Free-running tick prescaler, wraps after TICK_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // LED mode selection: led request beats armed status.
  always_comb begin
    led_want = LED_OFF;
    if (bus.led) begin
      led_want = LED_FAST;
    end else if (bus.system_arm) begin
      led_want = LED_SLOW;
    end
  end

  // LED pattern: mode change restarts at the lit entry state.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_mode <= LED_OFF;
      lcnt     <= '0;
      lvl      <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      led_q <= lvl;
      if (led_want != led_mode) begin
        led_mode <= led_want;
        lcnt     <= '0;
        lvl      <= (led_want != LED_OFF);
      end else if (tick) begin
        case (led_mode)
          LED_FAST: lvl <= ~lvl;
          LED_SLOW: begin
            if (lvl && lcnt == LON_LAST) begin
              lvl  <= 1'b0;
              lcnt <= '0;
            end else if (!lvl && lcnt == LOFF_LAST) begin
              lvl  <= 1'b1;
              lcnt <= '0;
            end else begin
              lcnt <= lcnt + 1'b1;
            end
          end
          default: begin
            lvl  <= 1'b0;
            lcnt <= '0;
          end
        endcase
      end
    end
  end

  // Siren cadence with total sounding limit; a drop wins over mute.
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= S_IDLE;
      scnt    <= '0;
      tcnt    <= '0;
      siren_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      siren_q <= (st == S_ON);
      tmo_q   <= (st == S_MUTED);
      unique case (st)
        S_IDLE: begin
          if (bus.siren) begin
            st   <= S_ON;
            scnt <= '0;
            tcnt <= '0;
          end
        end
        S_ON, S_OFF: begin
          if (!bus.siren) begin
            st <= S_IDLE;
          end else if (tick) begin
            if (tcnt == TOT_LAST) begin
              st <= S_MUTED;
            end else begin
              tcnt <= tcnt + 1'b1;
              if (st == S_ON && scnt == SON_LAST) begin
                st   <= S_OFF;
                scnt <= '0;
              end else if (st == S_OFF && scnt == SOFF_LAST) begin
                st   <= S_ON;
                scnt <= '0;
              end else begin
                scnt <= scnt + 1'b1;
              end
            end
          end
        end
        S_MUTED: begin
          if (!bus.siren) begin
            st <= S_IDLE;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  // Fuel pump enable delay; any drop restarts the delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      pst     <= P_OFF;
      dcnt    <= '0;
      relay_q <= 1'b0;
    end else begin
      relay_q <= (pst == P_ON);
      if (!bus.fuel_pump_power) begin
        pst  <= P_OFF;
        dcnt <= '0;
      end else begin
        unique case (pst)
          P_OFF: begin
            dcnt <= '0;
            pst  <= (PUMP_DELAY_TICKS == 0) ? P_ON : P_WAIT;
          end
          P_WAIT: begin
            if (tick) begin
              if (dcnt == DLY_LAST) begin
                pst <= P_ON;
              end else begin
                dcnt <= dcnt + 1'b1;
              end
            end
          end
          P_ON: pst <= P_ON;
          default: pst <= P_OFF;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alarm_output_driver.sv
// tb_alarm_output_driver: scoreboard bench, expected output words are
// queued per cycle with the stimulus and popped as cycles complete.
module tb_alarm_output_driver;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alarm_output_driver_if bus ();
  alarm_output_driver_if bus4 ();

  alarm_output_driver #(
    .TICK_DIV(1), .LED_ON_TICKS(2), .LED_OFF_TICKS(6),
    .SIREN_ON_TICKS(3), .SIREN_OFF_TICKS(2),
    .SIREN_MAX_TICKS(10), .PUMP_DELAY_TICKS(2)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  alarm_output_driver #(
    .TICK_DIV(4), .LED_ON_TICKS(2), .LED_OFF_TICKS(6),
    .SIREN_ON_TICKS(3), .SIREN_OFF_TICKS(2),
    .SIREN_MAX_TICKS(10), .PUMP_DELAY_TICKS(2)
  ) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave)
  );

  // word layout {led_out, siren_out, pump_relay, siren_timeout}
  localparam logic [3:0] ML = 4'b1000;
  localparam logic [3:0] MS = 4'b0100;
  localparam logic [3:0] MP = 4'b0010;
  localparam logic [3:0] MT = 4'b0001;

  typedef struct {
    int         cyc;
    logic [3:0] mask;
    logic [3:0] val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [3:0] obs();
    return {bus.led_out, bus.siren_out,
            bus.pump_relay, bus.siren_timeout};
  endfunction

  function automatic logic [3:0] obs4();
    return {bus4.led_out, bus4.siren_out,
            bus4.pump_relay, bus4.siren_timeout};
  endfunction

  function automatic void push_exp(int c, logic [3:0] m,
                                   logic [3:0] v);
    exp_t e;
    e.cyc  = c;
    e.mask = m;
    e.val  = v & m;
    sb.push_back(e);
  endfunction

  task automatic zero_inputs();
    bus.system_arm = 1'b0;
    bus.siren = 1'b0;
    bus.led = 1'b0;
    bus.fuel_pump_power = 1'b0;
    bus4.system_arm = 1'b0;
    bus4.siren = 1'b0;
    bus4.led = 1'b0;
    bus4.fuel_pump_power = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    zero_inputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.system_arm = 1'b1;
    bus.siren = 1'b1;
    bus.led = 1'b1;
    bus.fuel_pump_power = 1'b1;
    bus4.siren = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs() !== 4'b0000) begin
      errors++;
      $display("FAIL reset got=%b want=0000", obs());
    end
    checks++;
    if (obs4() !== 4'b0000) begin
      errors++;
      $display("FAIL reset_div4 got=%b want=0000", obs4());
    end
    zero_inputs();
  endtask

  task automatic test_siren_mute();
    exp_t e;
    logic s, t;
    do_reset();
    bus.siren = 1'b1;
    for (int k = 0; k <= 17; k++) begin
      s = (k >= 1 && k <= 3) || (k >= 6 && k <= 8);
      t = (k >= 11 && k <= 16);
      push_exp(k, MS | MT, {1'b0, s, 1'b0, t});
    end
    for (int k = 0; k <= 17; k++) begin
      @(posedge clk);
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc == k) begin
        e = sb.pop_front();
        checks++;
        if ((obs() & e.mask) !== e.val) begin
          errors++;
          $display("FAIL siren_mute cyc=%0d got=%b want=%b",
                   k, obs() & e.mask, e.val);
        end
      end
      if (k == 15) bus.siren = 1'b0;
    end
  endtask

  task automatic test_siren_abort();
    exp_t e;
    logic s;
    do_reset();
    bus.siren = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      s = (k >= 1 && k <= 3) || (k >= 8 && k <= 10) ||
          (k >= 13 && k <= 14);
      push_exp(k, MS, {1'b0, s, 2'b00});
    end
    for (int k = 0; k <= 16; k++) begin
      @(posedge clk);
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc == k) begin
        e = sb.pop_front();
        checks++;
        if ((obs() & e.mask) !== e.val) begin
          errors++;
          $display("FAIL siren_abort cyc=%0d got=%b want=%b",
                   k, obs() & e.mask, e.val);
        end
      end
      if (k == 3) bus.siren = 1'b0;
      if (k == 6) bus.siren = 1'b1;
      if (k == 13) bus.siren = 1'b0;
    end
  endtask

  task automatic test_led_priority();
    exp_t e;
    do_reset();
    bus.system_arm = 1'b1;
    push_exp(0, ML, 4'b0000);
    for (int k = 1; k <= 16; k++) begin
      push_exp(k, ML, {(((k - 1) % 8) < 2), 3'b000});
    end
    for (int k = 18; k <= 23; k++) begin
      push_exp(k, ML, {(k % 2 == 0), 3'b000});
    end
    for (int k = 25; k <= 33; k++) begin
      push_exp(k, ML, {(k <= 26 || k == 33), 3'b000});
    end
    push_exp(35, ML, 4'b0000);
    for (int k = 0; k <= 35; k++) begin
      @(posedge clk);
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc == k) begin
        e = sb.pop_front();
        checks++;
        if ((obs() & e.mask) !== e.val) begin
          errors++;
          $display("FAIL led_priority cyc=%0d got=%b want=%b",
                   k, obs() & e.mask, e.val);
        end
      end
      if (k == 16) bus.led = 1'b1;
      if (k == 23) bus.led = 1'b0;
      if (k == 33) bus.system_arm = 1'b0;
    end
  endtask

  task automatic test_pump();
    exp_t e;
    logic p;
    do_reset();
    bus.fuel_pump_power = 1'b1;
    for (int k = 0; k <= 17; k++) begin
      p = (k >= 3 && k <= 7) || (k >= 16);
      push_exp(k, MP, {2'b00, p, 1'b0});
    end
    for (int k = 0; k <= 17; k++) begin
      @(posedge clk);
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc == k) begin
        e = sb.pop_front();
        checks++;
        if ((obs() & e.mask) !== e.val) begin
          errors++;
          $display("FAIL pump cyc=%0d got=%b want=%b",
                   k, obs() & e.mask, e.val);
        end
      end
      if (k == 6) bus.fuel_pump_power = 1'b0;
      if (k == 8) bus.fuel_pump_power = 1'b1;
      if (k == 10) bus.fuel_pump_power = 1'b0;
      if (k == 12) bus.fuel_pump_power = 1'b1;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    do_reset();
    bus.system_arm = 1'b1;
    bus.siren = 1'b1;
    bus.fuel_pump_power = 1'b1;
    push_exp(6, 4'b1111, 4'b0110);
    push_exp(7, 4'b1111, 4'b0000);
    push_exp(8, 4'b1111, 4'b0000);
    push_exp(9, 4'b1111, 4'b1100);
    push_exp(10, 4'b1111, 4'b1100);
    push_exp(11, 4'b1111, 4'b0110);
    push_exp(12, 4'b1111, 4'b0010);
    push_exp(13, 4'b1111, 4'b0010);
    push_exp(14, 4'b1111, 4'b0110);
    for (int k = 0; k <= 14; k++) begin
      @(posedge clk);
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc == k) begin
        e = sb.pop_front();
        checks++;
        if ((obs() & e.mask) !== e.val) begin
          errors++;
          $display("FAIL reset_mid cyc=%0d got=%b want=%b",
                   k, obs() & e.mask, e.val);
        end
      end
      if (k == 6) rst = 1'b1;
      if (k == 7) rst = 1'b0;
    end
  endtask

  task automatic test_prescaler();
    int r1 = -1;
    int f1 = -1;
    int r2 = -1;
    int tm = -1;
    do_reset();
    bus4.siren = 1'b1;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (r1 < 0 && bus4.siren_out) r1 = k;
      else if (r1 >= 0 && f1 < 0 && !bus4.siren_out) f1 = k;
      else if (f1 >= 0 && r2 < 0 && bus4.siren_out) r2 = k;
      if (tm < 0 && bus4.siren_timeout) tm = k;
    end
    checks++;
    if (r1 < 0 || f1 < 0 || r2 < 0 || tm < 0) begin
      errors++;
      $display("FAIL div4_events r1=%0d f1=%0d r2=%0d tm=%0d",
               r1, f1, r2, tm);
    end else begin
      checks++;
      if (f1 - r1 < 9 || f1 - r1 > 12) begin
        errors++;
        $display("FAIL div4_on_len got=%0d want=9..12", f1 - r1);
      end
      checks++;
      if (r2 - f1 < 5 || r2 - f1 > 8) begin
        errors++;
        $display("FAIL div4_off_len got=%0d want=5..8", r2 - f1);
      end
      checks++;
      if (tm - r1 < 37 || tm - r1 > 40) begin
        errors++;
        $display("FAIL div4_mute got=%0d want=37..40", tm - r1);
      end
    end
    checks++;
    if (obs4() !== 4'b0001) begin
      errors++;
      $display("FAIL div4_muted got=%b want=0001", obs4());
    end
    bus4.siren = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs4() !== 4'b0000) begin
      errors++;
      $display("FAIL div4_release got=%b want=0000", obs4());
    end
  endtask

  initial begin
    rst = 1'b1;
    zero_inputs();
    test_reset();
    test_siren_mute();
    test_siren_abort();
    test_led_priority();
    test_pump();
    test_reset_mid();
    test_prescaler();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
